// File: rtl/rf_pkg.sv
// Shared register-file constants, arbiter state type and round-robin pointer helper.
package rf_pkg;

    localparam int RF_ADDR_W  = 3;
    localparam int RF_DATA_W  = 8;
    localparam int RR_IDX_W   = 2;
    localparam int LOCK_CNT_W = 4;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } rf_arb_state_t;

    // Next round-robin start position after index idx, wrapping at n requesters.
    function automatic logic [RR_IDX_W-1:0] rr_next(input logic [RR_IDX_W-1:0] idx, input int n);
        rr_next = (int'(idx) >= n - 32'sd1) ? {RR_IDX_W{1'b0}}
                                            : idx + {{(RR_IDX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first set request at or above ptr.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot_s;
    logic [N-1:0] rot_gnt_s;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_s     = N'({req, req} >> ptr);
        rot_gnt_s = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
        gnt       = N'(({rot_gnt_s, rot_gnt_s} << ptr) >> N);
    end

endmodule

// File: rtl/rf_arbiter.sv
// Round-robin arbiter sharing one 8x8 register file between N_REQ requesters,
// with a bounded ownership lock for atomic read-modify-write sequences.
module rf_arbiter
    import rf_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             lock,
    input  logic [N_REQ-1:0]             we,
    input  logic [RF_ADDR_W*N_REQ-1:0]   addr_a,
    input  logic [RF_ADDR_W*N_REQ-1:0]   addr_b,
    input  logic [RF_DATA_W*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             rvalid,
    output logic [RF_DATA_W-1:0]         rdata_a,
    output logic [RF_DATA_W-1:0]         rdata_b,
    output logic                         locked,
    output logic                         lock_timeout,
    output logic [RF_ADDR_W-1:0]         rf_addr_a,
    output logic [RF_ADDR_W-1:0]         rf_addr_b,
    output logic [RF_DATA_W-1:0]         rf_din,
    output logic                         rf_write,
    input  logic [RF_DATA_W-1:0]         rf_dout_a,
    input  logic [RF_DATA_W-1:0]         rf_dout_b
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX);

    rf_arb_state_t           state_q, state_d;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]           owner_q, owner_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]        rvalid_q, rvalid_d;
    logic [RF_DATA_W-1:0]    rdata_a_q, rdata_a_d;
    logic [RF_DATA_W-1:0]    rdata_b_q, rdata_b_d;
    logic                    locked_q, locked_d;
    logic                    lock_timeout_q, lock_timeout_d;

    logic [N_REQ-1:0]        arb_gnt_s;
    logic [N_REQ-1:0]        gnt_s;
    logic [PW-1:0]           gnt_idx_s;
    logic                    any_gnt_s;
    logic                    rd_gnt_s;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt_s)
    );

    // Grant: round-robin pick in ARB, owner only while LOCKED, nothing during reset.
    always_comb begin
        gnt_s = {N_REQ{1'b0}};
        if (!rst_n) begin
            gnt_s = {N_REQ{1'b0}};
        end else if (state_q == LOCKED) begin
            gnt_s[owner_q] = req[owner_q];
        end else begin
            gnt_s = arb_gnt_s;
        end
    end

    // Encode the one-hot grant into an index for the datapath muxes.
    always_comb begin
        gnt_idx_s = {PW{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            gnt_idx_s = gnt_s[i] ? PW'(i) : gnt_idx_s;
        end
        any_gnt_s = |gnt_s;
        rd_gnt_s  = any_gnt_s & ~we[gnt_idx_s];
    end

    // Route the granted requester's address/data onto the rf ports.
    always_comb begin
        if (any_gnt_s) begin
            rf_addr_a = addr_a[gnt_idx_s*RF_ADDR_W +: RF_ADDR_W];
            rf_addr_b = addr_b[gnt_idx_s*RF_ADDR_W +: RF_ADDR_W];
            rf_din    = wdata[gnt_idx_s*RF_DATA_W +: RF_DATA_W];
            rf_write  = we[gnt_idx_s];
        end else begin
            rf_addr_a = {RF_ADDR_W{1'b0}};
            rf_addr_b = {RF_ADDR_W{1'b0}};
            rf_din    = {RF_DATA_W{1'b0}};
            rf_write  = 1'b0;
        end
    end

    // Arbitration state, pointer and lock bookkeeping.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;
        case (state_q)
            ARB: begin
                if (any_gnt_s) begin
                    rr_ptr_d = PW'(rr_next(RR_IDX_W'(gnt_idx_s), N_REQ));
                    if (lock[gnt_idx_s]) begin
                        state_d    = LOCKED;
                        owner_d    = gnt_idx_s;
                        lock_cnt_d = 4'd1;
                    end else begin
                        state_d = ARB;
                    end
                end else begin
                    state_d = ARB;
                end
            end
            LOCKED: begin
                // A grant at the limit still completes; the release is forced afterwards.
                if (!req[owner_q] || !lock[owner_q] || (lock_cnt_q == LOCK_LIMIT)) begin
                    state_d        = ARB;
                    rr_ptr_d       = PW'(rr_next(RR_IDX_W'(owner_q), N_REQ));
                    lock_cnt_d     = {LOCK_CNT_W{1'b0}};
                    lock_timeout_d = req[owner_q] & (lock_cnt_q == LOCK_LIMIT);
                end else begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = {LOCK_CNT_W{1'b0}};
            end
        endcase
    end

    // Read return: capture rf outputs on a read grant, otherwise hold the data.
    always_comb begin
        rvalid_d  = rd_gnt_s ? gnt_s : {N_REQ{1'b0}};
        rdata_a_d = rd_gnt_s ? rf_dout_a : rdata_a_q;
        rdata_b_d = rd_gnt_s ? rf_dout_b : rdata_b_q;
        locked_d  = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB;
            rr_ptr_q       <= {PW{1'b0}};
            owner_q        <= {PW{1'b0}};
            lock_cnt_q     <= {LOCK_CNT_W{1'b0}};
            rvalid_q       <= {N_REQ{1'b0}};
            rdata_a_q      <= {RF_DATA_W{1'b0}};
            rdata_b_q      <= {RF_DATA_W{1'b0}};
            locked_q       <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            lock_cnt_q     <= lock_cnt_d;
            rvalid_q       <= rvalid_d;
            rdata_a_q      <= rdata_a_d;
            rdata_b_q      <= rdata_b_d;
            locked_q       <= locked_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign gnt          = gnt_s;
    assign rvalid       = rvalid_q;
    assign rdata_a      = rdata_a_q;
    assign rdata_b      = rdata_b_q;
    assign locked       = locked_q;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: directed scenarios plus a randomized run against a queue-free reference model.
module tb_rf_arbiter;

    localparam int N  = 2;
    localparam int LM = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req, lock, we;
    logic [3*N-1:0]   addr_a, addr_b;
    logic [8*N-1:0]   wdata;
    logic [N-1:0]     gnt, rvalid;
    logic [7:0]       rdata_a, rdata_b;
    logic             locked, lock_timeout;
    logic [2:0]       rf_addr_a, rf_addr_b;
    logic [7:0]       rf_din;
    logic             rf_write;
    logic [7:0]       rf_dout_a, rf_dout_b;

    logic [7:0]       rf_mem [8];
    logic             pre_en;
    logic [2:0]       pre_addr;
    logic [7:0]       pre_data;

    int total;
    int bad;
    int m_mem [8];

    rf_arbiter #(.N_REQ(N), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr_a(addr_a), .addr_b(addr_b), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .locked(locked), .lock_timeout(lock_timeout),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_din(rf_din), .rf_write(rf_write),
        .rf_dout_a(rf_dout_a), .rf_dout_b(rf_dout_b)
    );

    always #5 clk = ~clk;

    // Register file seen by the arbiter: combinational read, write on the clock edge.
    assign rf_dout_a = rf_mem[rf_addr_a];
    assign rf_dout_b = rf_mem[rf_addr_b];
    always @(posedge clk) begin
        if (pre_en) rf_mem[pre_addr] <= pre_data;
        else if (rf_write) rf_mem[rf_addr_a] <= rf_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req = '0; lock = '0; we = '0; addr_a = '0; addr_b = '0; wdata = '0;
    endtask

    task automatic set_port(input int i, input logic r, input logic l, input logic w,
                            input logic [2:0] aa, input logic [2:0] ab, input logic [7:0] wd);
        req[i] = r; lock[i] = l; we[i] = w;
        addr_a[i*3 +: 3] = aa; addr_b[i*3 +: 3] = ab; wdata[i*8 +: 8] = wd;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
        m_mem[a] = int'(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_port(0, 1'b1, 1'b0, 1'b1, 3'd1, 3'd2, 8'hFF);
        set_port(1, 1'b1, 1'b1, 1'b1, 3'd3, 3'd4, 8'hEE);
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write: got %b want 0", rf_write); end
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
        total++; if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h/%h want 00/00", rdata_a, rdata_b); end
        total++; if (locked !== 1'b0 || lock_timeout !== 1'b0) begin bad++; $display("FAIL reset_lock: got %b/%b want 0/0", locked, lock_timeout); end
        rst_n = 1'b1;
        clear_in();
        for (int i = 0; i < 8; i++) preload(3'(i), 8'(i * 16 + i));
    endtask

    task automatic test_single_read();
        do_reset();
        preload(3'd3, 8'h11);
        preload(3'd5, 8'h22);
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd5, 8'h00);
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", gnt); end
        total++; if (rf_addr_a !== 3'd3 || rf_addr_b !== 3'd5 || rf_write !== 1'b0) begin
            bad++; $display("FAIL single_rf_drive: got a=%0d b=%0d w=%b want 3 5 0", rf_addr_a, rf_addr_b, rf_write); end
        tick();
        clear_in();
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL single_rvalid: got %b want 01", rvalid); end
        total++; if (rdata_a !== 8'h11 || rdata_b !== 8'h22) begin bad++; $display("FAIL single_rdata: got %h/%h want 11/22", rdata_a, rdata_b); end
        tick();
        total++; if (rvalid !== 2'b00 || rdata_a !== 8'h11) begin bad++; $display("FAIL single_hold: got %b/%h want 00/11", rvalid, rdata_a); end
    endtask

    task automatic test_contention();
        logic [1:0] prev;
        logic [1:0] exp;
        do_reset();
        preload(3'd3, 8'h33);
        preload(3'd5, 8'h55);
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd5, 8'h00);
        prev = 2'b00;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (gnt !== exp) begin bad++; $display("FAIL contention_gnt[%0d]: got %b want %b", c, gnt, exp); end
            total++; if (rvalid !== prev) begin bad++; $display("FAIL contention_rvalid[%0d]: got %b want %b", c, rvalid, prev); end
            if (c > 0) begin
                total++; if (rdata_a !== ((prev == 2'b01) ? 8'h33 : 8'h55)) begin
                    bad++; $display("FAIL contention_rdata[%0d]: got %h", c, rdata_a); end
            end
            tick();
            prev = exp;
        end
        clear_in();
        total++; if (rvalid !== 2'b10 || rdata_a !== 8'h55) begin bad++; $display("FAIL contention_last: got %b/%h want 10/55", rvalid, rdata_a); end
    endtask

    task automatic test_write_read();
        do_reset();
        preload(3'd7, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 8'hA5);
        #1;
        total++; if (gnt !== 2'b10 || rf_write !== 1'b1 || rf_addr_a !== 3'd7 || rf_din !== 8'hA5) begin
            bad++; $display("FAIL write_drive: got g=%b w=%b a=%0d d=%h want 10 1 7 a5", gnt, rf_write, rf_addr_a, rf_din); end
        tick();
        clear_in();
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd7, 3'd7, 8'h00);
        #1;
        total++; if (gnt !== 2'b10 || rvalid !== 2'b00) begin bad++; $display("FAIL write_no_rvalid: got %b/%b want 10/00", gnt, rvalid); end
        tick();
        clear_in();
        total++; if (rvalid !== 2'b10 || rdata_a !== 8'hA5 || rdata_b !== 8'hA5) begin
            bad++; $display("FAIL write_readback: got %b %h/%h want 10 a5/a5", rvalid, rdata_a, rdata_b); end
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 8'h00);
        #1;
        tick();
        clear_in();
        set_port(1, 1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 8'h5A);
        #1;
        total++; if (gnt !== 2'b10 || rvalid !== 2'b01 || rdata_a !== 8'hA5) begin
            bad++; $display("FAIL raw_preread: got %b %b %h want 10 01 a5", gnt, rvalid, rdata_a); end
        tick();
        clear_in();
        total++; if (rvalid !== 2'b00 || rdata_a !== 8'hA5) begin bad++; $display("FAIL raw_hold: got %b/%h want 00/a5", rvalid, rdata_a); end
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 8'h00);
        #1;
        tick();
        clear_in();
        total++; if (rvalid !== 2'b01 || rdata_a !== 8'h5A) begin bad++; $display("FAIL raw_postread: got %b/%h want 01/5a", rvalid, rdata_a); end
    endtask

    task automatic test_lock_timeout();
        do_reset();
        set_port(0, 1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd4, 8'h00);
        #1;
        total++; if (gnt !== 2'b01 || locked !== 1'b0) begin bad++; $display("FAIL lock_entry: got %b/%b want 01/0", gnt, locked); end
        tick();
        for (int c = 1; c <= LM; c++) begin
            total++; if (gnt !== 2'b01 || locked !== 1'b1 || lock_timeout !== 1'b0) begin
                bad++; $display("FAIL lock_hold[%0d]: got g=%b l=%b t=%b want 01 1 0", c, gnt, locked, lock_timeout); end
            tick();
        end
        total++; if (lock_timeout !== 1'b1 || locked !== 1'b0 || gnt !== 2'b10) begin
            bad++; $display("FAIL lock_timeout: got t=%b l=%b g=%b want 1 0 10", lock_timeout, locked, gnt); end
        tick();
        total++; if (lock_timeout !== 1'b0) begin bad++; $display("FAIL lock_timeout_pulse: got %b want 0", lock_timeout); end
        clear_in();
    endtask

    task automatic test_lock_early_release();
        do_reset();
        set_port(0, 1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 8'h00);
        #1;
        tick();
        total++; if (gnt !== 2'b01 || locked !== 1'b1) begin bad++; $display("FAIL early_second: got %b/%b want 01/1", gnt, locked); end
        tick();
        set_port(0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 8'h00);
        #1;
        total++; if (gnt !== 2'b00 || locked !== 1'b1) begin bad++; $display("FAIL early_drop: got %b/%b want 00/1", gnt, locked); end
        tick();
        total++; if (gnt !== 2'b10 || locked !== 1'b0) begin bad++; $display("FAIL early_after_drop: got %b/%b want 10/0", gnt, locked); end
        do_reset();
        set_port(0, 1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 8'h00);
        #1;
        tick();
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 8'h00);
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL early_unlock_gnt: got %b want 01", gnt); end
        tick();
        total++; if (gnt !== 2'b10 || locked !== 1'b0) begin bad++; $display("FAIL early_after_unlock: got %b/%b want 10/0", gnt, locked); end
        clear_in();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_port(0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd5, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd6, 8'h00);
        #1;
        tick();
        total++; if (gnt !== 2'b01 || locked !== 1'b1) begin bad++; $display("FAIL midlock_pre: got %b/%b want 01/1", gnt, locked); end
        rst_n = 1'b0;
        #1;
        total++; if (rvalid !== 2'b00 || locked !== 1'b0 || gnt !== 2'b00) begin
            bad++; $display("FAIL midlock_reset: got r=%b l=%b g=%b want 00 0 00", rvalid, locked, gnt); end
        tick();
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL midlock_no_rvalid: got %b want 00", rvalid); end
        rst_n = 1'b1;
        clear_in();
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd6, 8'h00);
        #1;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL midlock_req10: got %b want 10", gnt); end
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd5, 8'h00);
        #1;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL midlock_req11: got %b want 01", gnt); end
        clear_in();
        tick();
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL midlock_idle: got %b want 00", rvalid); end
    endtask

    task automatic test_random();
        int         m_ptr, m_owner, m_cnt, g, idx;
        bit         m_lk;
        logic [1:0] x_gnt, e_rvalid;
        logic [2:0] x_aa, x_ab;
        logic [7:0] x_din, e_rda, e_rdb;
        logic       x_wr, e_to;
        do_reset();
        for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom_range(0, 255)));
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_lk = 1'b0;
        e_rvalid = 2'b00; e_rda = 8'h00; e_rdb = 8'h00; e_to = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++)
                set_port(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            #1;
            g = -1;
            if (!m_lk) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req[idx]) g = idx;
                end
            end else if (req[m_owner]) begin
                g = m_owner;
            end
            x_gnt = 2'b00; x_aa = 3'd0; x_ab = 3'd0; x_din = 8'h00; x_wr = 1'b0;
            if (g >= 0) begin
                x_gnt[g] = 1'b1; x_aa = addr_a[g*3 +: 3]; x_ab = addr_b[g*3 +: 3];
                x_din = wdata[g*8 +: 8]; x_wr = we[g];
            end
            total++; if (gnt !== x_gnt) begin bad++; $display("FAIL rand_gnt[%0d]: got %b want %b", cyc, gnt, x_gnt); end
            total++; if (rf_write !== x_wr) begin bad++; $display("FAIL rand_rf_write[%0d]: got %b want %b", cyc, rf_write, x_wr); end
            total++; if (rf_addr_a !== x_aa || rf_addr_b !== x_ab) begin
                bad++; $display("FAIL rand_rf_addr[%0d]: got %0d/%0d want %0d/%0d", cyc, rf_addr_a, rf_addr_b, x_aa, x_ab); end
            total++; if (rf_din !== x_din) begin bad++; $display("FAIL rand_rf_din[%0d]: got %h want %h", cyc, rf_din, x_din); end
            total++; if (rvalid !== e_rvalid) begin bad++; $display("FAIL rand_rvalid[%0d]: got %b want %b", cyc, rvalid, e_rvalid); end
            total++; if (rdata_a !== e_rda || rdata_b !== e_rdb) begin
                bad++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", cyc, rdata_a, rdata_b, e_rda, e_rdb); end
            total++; if (locked !== m_lk) begin bad++; $display("FAIL rand_locked[%0d]: got %b want %b", cyc, locked, m_lk); end
            total++; if (lock_timeout !== e_to) begin bad++; $display("FAIL rand_timeout[%0d]: got %b want %b", cyc, lock_timeout, e_to); end
            e_to = 1'b0;
            if (g >= 0 && !we[g]) begin
                e_rvalid = x_gnt; e_rda = 8'(m_mem[x_aa]); e_rdb = 8'(m_mem[x_ab]);
            end else begin
                e_rvalid = 2'b00;
            end
            if (g >= 0 && we[g]) m_mem[x_aa] = int'(x_din);
            if (!m_lk) begin
                if (g >= 0) begin
                    m_ptr = (g + 1) % N;
                    if (lock[g]) begin m_lk = 1'b1; m_owner = g; m_cnt = 1; end
                end
            end else if (g < 0 || !lock[g] || m_cnt == LM) begin
                e_to  = (g >= 0 && m_cnt == LM);
                m_lk  = 1'b0;
                m_ptr = (m_owner + 1) % N;
            end else begin
                m_cnt++;
            end
            tick();
        end
        clear_in();
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; pre_en = 1'b0; pre_addr = 3'd0; pre_data = 8'h00;
        clear_in();
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_lock_timeout();
        test_lock_early_release();
        test_reset_mid_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
